// File: rtl/packet_assembler.sv
// HDMI data-island packet serializer: 24-bit header + four 56-bit subpackets into 32 slots of 9 bits.
// Define HDMI_PACKET_ECC_EN to build the BCH parity LFSRs; otherwise the ECC slots carry zeros.
module packet_assembler (
  input  logic             clk_pixel,
  input  logic             reset,
  input  logic             data_island_period,
  input  logic [23:0]      header,
  input  logic [3:0][55:0] sub,
  output logic [8:0]       packet_data,
  output logic             packet_valid,
  output logic [4:0]       counter,
  output logic             clk_packet
);
  localparam int NUM_LANES = 4;

  logic [4:0]                  c;
  logic [23:0]                 hdr_q;
  logic [NUM_LANES-1:0][55:0]  sub_q;
  logic [23:0]                 hdr_cur;
  logic [NUM_LANES-1:0][55:0]  sub_cur;
  logic [31:0]                 hdr_ext;
  logic                        hbit;
  logic                        hdr_out;
  logic [NUM_LANES-1:0]        lane_even;
  logic [NUM_LANES-1:0]        lane_odd;
  logic                        first_slot;

`ifdef HDMI_PACKET_ECC_EN
  function automatic logic [7:0] bch_step(input logic [7:0] e, input logic b);
    return {1'b0, e[7:1]} ^ ({8{e[0] ^ b}} & 8'h83);
  endfunction
`endif

  // Slot 0 reads the live inputs so back-to-back packets need no bubble.
  assign first_slot = (c == 5'd0);
  assign hdr_cur    = first_slot ? header : hdr_q;
  assign sub_cur    = first_slot ? sub    : sub_q;
  assign hdr_ext    = {8'b0, hdr_cur};
  assign hbit       = hdr_ext[c];

`ifdef HDMI_PACKET_ECC_EN
  logic [7:0] hecc, hecc_in, hecc_nxt;
  assign hecc_in  = first_slot ? 8'h00 : hecc;
  assign hecc_nxt = (c < 5'd24) ? bch_step(hecc_in, hbit) : hecc_in;
  assign hdr_out  = (c < 5'd24) ? hbit : hecc[c[2:0]];

  always_ff @(posedge clk_pixel) begin
    if (reset || !data_island_period) hecc <= 8'h00;
    else                              hecc <= hecc_nxt;
  end
`else
  assign hdr_out = (c < 5'd24) ? hbit : 1'b0;
`endif

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [63:0] ext;
    logic        ev, od;
    assign ext = {8'b0, sub_cur[k]};
    assign ev  = ext[{c, 1'b0}];
    assign od  = ext[{c, 1'b1}];
`ifdef HDMI_PACKET_ECC_EN
    logic [7:0] ecc, ecc_in, ecc_nxt;
    assign ecc_in  = first_slot ? 8'h00 : ecc;
    assign ecc_nxt = (c < 5'd28) ? bch_step(bch_step(ecc_in, ev), od) : ecc_in;
    assign lane_even[k] = (c < 5'd28) ? ev : ecc[{c[1:0], 1'b0}];
    assign lane_odd[k]  = (c < 5'd28) ? od : ecc[{c[1:0], 1'b1}];

    always_ff @(posedge clk_pixel) begin
      if (reset || !data_island_period) ecc <= 8'h00;
      else                              ecc <= ecc_nxt;
    end
`else
    assign lane_even[k] = (c < 5'd28) ? ev : 1'b0;
    assign lane_odd[k]  = (c < 5'd28) ? od : 1'b0;
`endif
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      hdr_q <= '0;
      sub_q <= '0;
    end else if (data_island_period && first_slot) begin
      hdr_q <= header;
      sub_q <= sub;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      c            <= 5'd0;
      packet_data  <= 9'd0;
      packet_valid <= 1'b0;
      counter      <= 5'd0;
      clk_packet   <= 1'b0;
    end else if (data_island_period) begin
      c            <= c + 5'd1;
      packet_data  <= {lane_odd, lane_even, hdr_out};
      packet_valid <= 1'b1;
      counter      <= c;
      clk_packet   <= (c == 5'd31);
    end else begin
      c            <= 5'd0;
      packet_data  <= 9'd0;
      packet_valid <= 1'b0;
      counter      <= 5'd0;
      clk_packet   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_packet_assembler.sv
// Directed bench for packet_assembler; expected ECC follows HDMI_PACKET_ECC_EN like the design.
module tb_packet_assembler;
  logic             clk_pixel = 1'b0;
  logic             reset;
  logic             data_island_period;
  logic [23:0]      header;
  logic [3:0][55:0] sub;
  logic [8:0]       packet_data;
  logic             packet_valid;
  logic [4:0]       counter;
  logic             clk_packet;

  int checks   = 0;
  int failures = 0;

  packet_assembler dut (
    .clk_pixel(clk_pixel), .reset(reset), .data_island_period(data_island_period),
    .header(header), .sub(sub), .packet_data(packet_data), .packet_valid(packet_valid),
    .counter(counter), .clk_packet(clk_packet)
  );

  always #5 clk_pixel = ~clk_pixel;

  function automatic logic [7:0] bch(input logic [7:0] e, input logic b);
    return {1'b0, e[7:1]} ^ ({8{e[0] ^ b}} & 8'h83);
  endfunction

  // Reference slot: full-packet ECC computed up front, then the slot is picked out.
  function automatic logic [8:0] exp_slot(input logic [23:0] h, input logic [3:0][55:0] s, input int c);
    logic [7:0]      he;
    logic [3:0][7:0] se;
    logic [8:0]      r;
    he = '0; se = '0; r = '0;
`ifdef HDMI_PACKET_ECC_EN
    for (int i = 0; i < 24; i++) he = bch(he, h[i]);
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 56; i++) se[k] = bch(se[k], s[k][i]);
`endif
    r[0] = (c < 24) ? h[c] : he[c-24];
    for (int k = 0; k < 4; k++) begin
      r[1+k] = (c < 28) ? s[k][2*c]   : se[k][2*c-56];
      r[5+k] = (c < 28) ? s[k][2*c+1] : se[k][2*c-55];
    end
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk_pixel); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; data_island_period = 1'b0; header = '0; sub = '0;
    repeat (3) cycle();
    checks++;
    if ({packet_data, packet_valid, counter, clk_packet} !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: got data=%h valid=%b cnt=%0d pkt=%b, want all 0",
               packet_data, packet_valid, counter, clk_packet);
    end
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_zero();
    int pulses = 0;
    header = '0; sub = '0; data_island_period = 1'b1;
    for (int i = 0; i < 32; i++) begin
      cycle();
      checks++;
      if (packet_data !== 9'd0 || counter !== i[4:0] || packet_valid !== 1'b1) begin
        failures++;
        $display("FAIL zero_slot%0d: got data=%h cnt=%0d valid=%b, want 0/%0d/1", i, packet_data, counter, packet_valid, i);
      end
      if (clk_packet) pulses++;
    end
    data_island_period = 1'b0;
    cycle();
    checks++;
    if (pulses != 1 || packet_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_pulses: got pulses=%0d valid=%b, want 1/0", pulses, packet_valid);
    end
  endtask

  task automatic test_header_ecc();
    logic [7:0] ecc_hand = 8'h83;
    header = 24'h800000; sub = '0; data_island_period = 1'b1;
    for (int i = 0; i < 32; i++) begin
      cycle();
      checks++;
      if (packet_data !== exp_slot(24'h800000, '0, i) || clk_packet !== (i == 31)) begin
        failures++;
        $display("FAIL hdr_ecc_slot%0d: got data=%h pkt=%b, want %h/%b", i, packet_data, clk_packet,
                 exp_slot(24'h800000, '0, i), (i == 31));
      end
`ifdef HDMI_PACKET_ECC_EN
      if (i >= 24) begin
        checks++;
        if (packet_data[0] !== ecc_hand[i-24]) begin
          failures++;
          $display("FAIL hdr_ecc_bit%0d: got %b want %b", i - 24, packet_data[0], ecc_hand[i-24]);
        end
      end
`endif
      if (i == 23) begin
        checks++;
        if (packet_data !== 9'h001) begin
          failures++;
          $display("FAIL hdr_bit23: got %h want 001", packet_data);
        end
      end
    end
    data_island_period = 1'b0;
    cycle();
  endtask

  task automatic test_sub_ecc();
    logic [3:0][55:0] s;
    s = '0; s[2] = 56'h80_0000_0000_0000;
    header = '0; sub = s; data_island_period = 1'b1;
    for (int i = 0; i < 32; i++) begin
      cycle();
      checks++;
      if (packet_data !== exp_slot('0, s, i) || counter !== i[4:0]) begin
        failures++;
        $display("FAIL sub_ecc_slot%0d: got data=%h cnt=%0d, want %h/%0d", i, packet_data, counter, exp_slot('0, s, i), i);
      end
      if (i == 27) begin
        checks++;
        if (packet_data !== 9'h080) begin
          failures++;
          $display("FAIL sub2_bit55: got %h want 080", packet_data);
        end
      end
`ifdef HDMI_PACKET_ECC_EN
      if (i == 28 || i == 31) begin
        checks++;
        if (packet_data !== ((i == 28) ? 9'h088 : 9'h080)) begin
          failures++;
          $display("FAIL sub2_ecc_slot%0d: got %h want %h", i, packet_data, (i == 28) ? 9'h088 : 9'h080);
        end
      end
`endif
    end
    data_island_period = 1'b0;
    cycle();
  endtask

  task automatic test_back_to_back();
    logic [3:0][55:0] s;
    int pulse_at[$];
    s[0] = 56'h12_3456_789A_BCDE; s[1] = 56'hFF_0000_FFFF_0001;
    s[2] = 56'h00_C0DE_0000_BEEF; s[3] = 56'hA5_A5A5_5A5A_5A5A;
    header = 24'h1357BD; sub = s; data_island_period = 1'b1;
    for (int i = 0; i < 64; i++) begin
      cycle();
      checks++;
      if (packet_data !== exp_slot((i < 32) ? 24'h1357BD : 24'hC3A50F, s, i % 32) || counter !== i[4:0]) begin
        failures++;
        $display("FAIL b2b_slot%0d: got data=%h cnt=%0d, want %h/%0d", i, packet_data, counter,
                 exp_slot((i < 32) ? 24'h1357BD : 24'hC3A50F, s, i % 32), i % 32);
      end
      if (clk_packet) pulse_at.push_back(i);
      if (i == 10) header = 24'hC3A50F;
    end
    data_island_period = 1'b0;
    cycle();
    checks++;
    if (pulse_at.size() != 2 || pulse_at[0] != 31 || pulse_at[1] != 63) begin
      failures++;
      $display("FAIL b2b_pulses: got count=%0d, want 2 at slots 31 and 63", pulse_at.size());
    end
  endtask

  task automatic test_abort();
    logic [3:0][55:0] s;
    int pulses = 0;
    s[0] = 56'h01_0203_0405_0607; s[1] = 56'h7F_7F7F_7F7F_7F7F;
    s[2] = 56'h80_0000_0000_0001; s[3] = 56'h3C_3C3C_3C3C_3C3C;
    header = 24'hFFFFFF; sub = s; data_island_period = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (clk_packet) pulses++;
    end
    data_island_period = 1'b0;
    header = 24'h0F0F0F;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (packet_valid !== 1'b0 || counter !== 5'd0 || clk_packet !== 1'b0) begin
        failures++;
        $display("FAIL abort_idle%0d: got valid=%b cnt=%0d pkt=%b, want 0/0/0", i, packet_valid, counter, clk_packet);
      end
    end
    data_island_period = 1'b1;
    for (int i = 0; i < 32; i++) begin
      cycle();
      checks++;
      if (packet_data !== exp_slot(24'h0F0F0F, s, i) || counter !== i[4:0]) begin
        failures++;
        $display("FAIL abort_restart_slot%0d: got data=%h cnt=%0d, want %h/%0d", i, packet_data, counter,
                 exp_slot(24'h0F0F0F, s, i), i);
      end
      if (clk_packet && i != 31) pulses++;
    end
    data_island_period = 1'b0;
    cycle();
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL abort_pulses: got %0d stray clk_packet, want 0", pulses);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0][55:0] s;
    s[0] = 56'hDE_ADBE_EF00_1122; s[1] = 56'h33_4455_6677_8899;
    s[2] = 56'hAA_BBCC_DDEE_FF00; s[3] = 56'h01_2345_6789_ABCD;
    header = 24'hABCDEF; sub = s; data_island_period = 1'b1;
    for (int i = 0; i < 21; i++) cycle();
    reset = 1'b1;
    cycle();
    checks++;
    if ({packet_data, packet_valid, counter, clk_packet} !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid: got data=%h valid=%b cnt=%0d pkt=%b, want all 0",
               packet_data, packet_valid, counter, clk_packet);
    end
    reset = 1'b0; data_island_period = 1'b0;
    cycle();
    header = 24'h654321; data_island_period = 1'b1;
    for (int i = 0; i < 32; i++) begin
      cycle();
      checks++;
      if (packet_data !== exp_slot(24'h654321, s, i) || clk_packet !== (i == 31)) begin
        failures++;
        $display("FAIL post_reset_slot%0d: got data=%h pkt=%b, want %h/%b", i, packet_data, clk_packet,
                 exp_slot(24'h654321, s, i), (i == 31));
      end
    end
    data_island_period = 1'b0;
    cycle();
  endtask

  initial begin
    test_reset();
    test_zero();
    test_header_ecc();
    test_sub_ecc();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
